// File: rtl/parity_encode_scheduler.sv
// parity_encode_scheduler: round-robin share of one majority-bit encoder between
// two requesters, with a single registered output stage tagged by source.
module parity_encode_scheduler #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [6:0]       a_data,
   input  logic             a_mode,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [6:0]       b_data,
   input  logic             b_mode,
   output logic             b_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t r_state, w_next;
   logic r_ptr;
   logic w_free, w_gnt_a, w_gnt_b, w_gnt, w_mode, w_bit;
   logic [6:0] w_d;
   logic [2:0] w_ones;
   assign w_free  = (r_state == EMPTY) || out_ready;
   // r_ptr=0 favours A on a tie, r_ptr=1 favours B
   assign w_gnt_a = w_free && a_valid && (!b_valid || !r_ptr);
   assign w_gnt_b = w_free && b_valid && (!a_valid || r_ptr);
   assign w_gnt   = w_gnt_a || w_gnt_b;
   assign a_ready = w_gnt_a;
   assign b_ready = w_gnt_b;
   assign w_d     = w_gnt_b ? b_data : a_data;
   assign w_mode  = w_gnt_b ? b_mode : a_mode;
   assign w_ones  = 3'($countones(w_d));
   assign w_bit   = w_mode ? (w_ones >= 3'd4) : (w_ones <= 3'd3);
   assign out_valid = (r_state == FULL);
   always_comb begin
      w_next = r_state;
      if (w_gnt)
         w_next = FULL;
      else if (out_ready)
         w_next = EMPTY;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= EMPTY;
         r_ptr    <= 1'b0;
         out_data <= '0;
         out_src  <= 1'b0;
         cnt_a    <= '0;
         cnt_b    <= '0;
      end else begin
         r_state <= w_next;
         if (w_gnt) begin
            out_data <= {w_d[6:4], w_bit, w_d[3:0]};
            out_src  <= w_gnt_b;
            r_ptr    <= w_gnt_a;
         end
         if (w_gnt_a)
            cnt_a <= cnt_a + 1'b1;
         if (w_gnt_b)
            cnt_b <= cnt_b + 1'b1;
      end
   end
endmodule

// File: tb/tb_parity_encode_scheduler.sv
// tb_parity_encode_scheduler: table-driven vectors, hand sequences and random
// stimulus checked against a transaction-level model of the scheduler.
module tb_parity_encode_scheduler;
   logic clk = 1'b0;
   logic rst, a_valid, a_mode, b_valid, b_mode, out_ready;
   logic [6:0] a_data, b_data;
   logic a_ready, b_ready, out_valid, out_src;
   logic [7:0] out_data, cnt_a, cnt_b;
   logic s_ar, s_br, s_ov, s_os;
   logic [7:0] s_od;
   logic [1:0] s_ca, s_cb;
   int checks = 0, errors = 0;
   bit m_full, m_ptr, m_src;
   logic [7:0] m_data;
   int m_ca, m_cb;

   always #5 clk = ~clk;

   parity_encode_scheduler dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_mode(a_mode), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_mode(b_mode), .b_ready(b_ready),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
      .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   parity_encode_scheduler #(.CNT_W(2)) dut_s (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_mode(a_mode), .a_ready(s_ar),
      .b_valid(b_valid), .b_data(b_data), .b_mode(b_mode), .b_ready(s_br),
      .out_valid(s_ov), .out_data(s_od), .out_src(s_os), .out_ready(out_ready),
      .cnt_a(s_ca), .cnt_b(s_cb)
   );

   typedef struct {
      logic av; logic [6:0] ad; logic am;
      logic bv; logic [6:0] bd; logic bm;
      logic ordy;
      logic ear; logic ebr; logic eov; logic [7:0] eod; logic eos;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] enc(input logic [6:0] d, input logic m);
      int ones = 0;
      for (int i = 0; i < 7; i++) ones += int'(d[i]);
      return {d[6:4], (m ? (ones > 3) : (ones < 4)), d[3:0]};
   endfunction

   task automatic m_reset();
      m_full = 0; m_ptr = 0; m_src = 0; m_data = 0; m_ca = 0; m_cb = 0;
   endtask

   task automatic cyc(output logic ar, output logic br);
      bit free, ga, gb;
      @(negedge clk);
      free = !m_full || out_ready;
      ga = free && a_valid && (!b_valid || !m_ptr);
      gb = free && b_valid && (!a_valid || m_ptr);
      ar = a_ready; br = b_ready;
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("out_valid", out_valid, m_full);
      chk("out_data", out_data, m_data);
      chk("out_src", out_src, m_src);
      chk("cnt_a", cnt_a, m_ca % 256);
      chk("cnt_b", cnt_b, m_cb % 256);
      chk("cnt_a_small", s_ca, m_ca % 4);
      chk("cnt_b_small", s_cb, m_cb % 4);
      @(posedge clk);
      if (rst) m_reset();
      else if (ga || gb) begin
         m_full = 1; m_src = gb; m_ptr = ga;
         m_data = gb ? enc(b_data, b_mode) : enc(a_data, a_mode);
         if (ga) m_ca++; else m_cb++;
      end else if (out_ready) m_full = 0;
      #1;
   endtask

   task automatic set_in(input logic av, input logic [6:0] ad, input logic am,
                         input logic bv, input logic [6:0] bd, input logic bm, input logic ordy);
      a_valid = av; a_data = ad; a_mode = am;
      b_valid = bv; b_data = bd; b_mode = bm; out_ready = ordy;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      m_reset();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not end, required finish");
      $fatal(1);
   end

   initial begin
      logic ar, br;
      int wexp[5] = '{1, 2, 3, 0, 1};
      tbl[0]  = '{1, 7'b1010101, 1, 0, 7'h00, 0, 1, 1, 0, 1, 8'hB5, 0};
      tbl[1]  = '{1, 7'b1010101, 0, 0, 7'h00, 0, 1, 1, 0, 1, 8'hA5, 0};
      tbl[2]  = '{0, 7'h00, 0, 1, 7'b0000000, 0, 1, 0, 1, 1, 8'h10, 1};
      tbl[3]  = '{0, 7'h00, 0, 0, 7'h00, 0, 1, 0, 0, 0, 8'h10, 1};
      tbl[4]  = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 1, 1, 0, 1, 8'h11, 0};
      tbl[5]  = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 1, 0, 1, 1, 8'hFF, 1};
      tbl[6]  = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 1, 1, 0, 1, 8'h11, 0};
      tbl[7]  = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 1, 0, 1, 1, 8'hFF, 1};
      tbl[8]  = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 0, 0, 0, 1, 8'hFF, 1};
      tbl[9]  = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 0, 0, 0, 1, 8'hFF, 1};
      tbl[10] = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 0, 0, 0, 1, 8'hFF, 1};
      tbl[11] = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 1, 1, 0, 1, 8'h11, 0};
      tbl[12] = '{0, 7'h00, 0, 0, 7'h00, 0, 1, 0, 0, 0, 8'h11, 0};
      tbl[13] = '{1, 7'b0000001, 0, 1, 7'b1111111, 1, 1, 0, 1, 1, 8'hFF, 1};
      set_in(0, 0, 0, 0, 0, 0, 0);
      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_cnt_b", cnt_b, 0);
      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i].av, tbl[i].ad, tbl[i].am, tbl[i].bv, tbl[i].bd, tbl[i].bm, tbl[i].ordy);
         cyc(ar, br);
         chk($sformatf("tbl%0d_a_ready", i), ar, tbl[i].ear);
         chk($sformatf("tbl%0d_b_ready", i), br, tbl[i].ebr);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].eov);
         chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].eod);
         chk($sformatf("tbl%0d_out_src", i), out_src, tbl[i].eos);
      end
      chk("tbl_cnt_a", cnt_a, 5);
      chk("tbl_cnt_b", cnt_b, 4);
      // reset while FULL with both requesters pending
      set_in(1, 7'h2A, 1, 1, 7'h55, 0, 0);
      cyc(ar, br);
      rst = 1'b1;
      cyc(ar, br);
      rst = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_cnt_a", cnt_a, 0);
      chk("midrst_cnt_b", cnt_b, 0);
      out_ready = 1'b1;
      cyc(ar, br);
      chk("midrst_first_a", ar, 1);
      chk("midrst_first_b", br, 0);
      chk("midrst_src", out_src, 0);
      // counter wrap on the narrow instance
      set_in(0, 0, 0, 0, 0, 0, 0);
      do_reset();
      set_in(1, 7'h33, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(ar, br);
         chk($sformatf("wrap%0d_cnt_a_small", i), s_ca, wexp[i]);
      end
      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         set_in($urandom_range(0, 1), 7'($urandom), $urandom_range(0, 1),
                $urandom_range(0, 1), 7'($urandom), $urandom_range(0, 1),
                $urandom_range(0, 9) < 7);
         cyc(ar, br);
      end
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 1);
      cyc(ar, br);
      cyc(ar, br);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
